// File: rtl/sh7604_ext_responder_pkg.sv
// Shared types for the SH7604 external-bus responder: FSM state encoding and
// the backend memory request bundle.
package sh7604_ext_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WDATA   = 2'd1,
        WAITACK = 2'd2,
        DONE    = 2'd3
    } RespState_t;

    typedef struct packed {
        logic [26:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        we;
        logic        req;
    } MemReq_t;

    localparam logic [3:0]  BE_ALL       = 4'hF;
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/sh7604_ext_responder.sv
// SH7604 normal-space bus target: turns each CPU cycle into one req/ack backend
// transaction. Define SH7604_RESP_TIMEOUT_EN to add the no-ack timeout.
module sh7604_ext_responder
    import sh7604_ext_responder_pkg::*;
#(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [26:0] A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        DOE,
    input  logic        CS_N,
    input  logic        BS_N,
    input  logic        RD_WR_N,
    input  logic        RD_N,
    input  logic [3:0]  WE_N,
    output logic        WAIT_N,
    output logic [26:0] MEM_A,
    output logic [31:0] MEM_DO,
    output logic [3:0]  MEM_BE,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic [31:0] MEM_DI,
    input  logic        MEM_ACK,
    output logic        TO_ERR
);

    RespState_t  state_q, state_d;
    MemReq_t     mem_q, mem_d;
    logic        dir_q, dir_d;          // 1 = read
    logic [3:0]  wcnt_q, wcnt_d;
    logic        ack_q, ack_d;
    logic [31:0] ackdata_q, ackdata_d;
    logic        cs_lost_q, cs_lost_d;
    logic [31:0] do_q, do_d;
    logic        doe_q, doe_d;
    logic        wait_n_q, wait_n_d;
    logic        ready;

`ifdef SH7604_RESP_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        to_err_q, to_err_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // RD_N carries no information beyond RD_WR_N for this target.
    logic unused_rd_n;
    assign unused_rd_n = RD_N;

    assign ready = ack_q && (wcnt_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        dir_d     = dir_q;
        wcnt_d    = wcnt_q;
        ack_d     = ack_q;
        ackdata_d = ackdata_q;
        cs_lost_d = cs_lost_q;
        do_d      = do_q;
        doe_d     = doe_q;
        wait_n_d  = wait_n_q;
`ifdef SH7604_RESP_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        to_err_d  = 1'b0;
`endif

        // Ack is taken on any CLK edge; the request drops at that same edge.
        if (MEM_ACK && mem_q.req) begin
            ack_d     = 1'b1;
            ackdata_d = MEM_DI;
            mem_d.req = 1'b0;
        end

        // A ready WAITACK releases WAIT_N early, which is what allows zero-wait cycles.
        if (CE_F) begin
            wait_n_d = !((state_q == WDATA) || ((state_q == WAITACK) && !ready));
        end

        if (CE_R) begin
            unique case (state_q)
                IDLE: begin
                    if (!CS_N && !BS_N) begin
                        mem_d.a   = A;
                        dir_d     = RD_WR_N;
                        wcnt_d    = 4'(MIN_WAIT);
                        cs_lost_d = 1'b0;
`ifdef SH7604_RESP_TIMEOUT_EN
                        tcnt_d    = 16'd0;
`endif
                        if (RD_WR_N) begin
                            mem_d.be  = BE_ALL;
                            mem_d.we  = 1'b0;
                            mem_d.req = 1'b1;
                            state_d   = WAITACK;
                        end else begin
                            state_d   = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (CS_N) begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                    end else if (WE_N != 4'hF) begin
                        mem_d.d   = DI;
                        mem_d.be  = ~WE_N;
                        mem_d.we  = 1'b1;
                        mem_d.req = 1'b1;
                        state_d   = WAITACK;
`ifdef SH7604_RESP_TIMEOUT_EN
                        tcnt_d    = 16'd0;
`endif
                    end
                end
                WAITACK: begin
                    if (CS_N) begin
                        cs_lost_d = 1'b1;
                    end
                    if (ready) begin
                        // A cycle the CPU has already abandoned completes silently.
                        if (cs_lost_q || CS_N) begin
                            state_d = IDLE;
                            ack_d   = 1'b0;
                        end else begin
                            state_d = DONE;
                            if (dir_q) begin
                                do_d  = ackdata_q;
                                doe_d = 1'b1;
                            end
                        end
                    end else begin
                        if (wcnt_q != 4'd0) begin
                            wcnt_d = wcnt_q - 4'd1;
                        end
`ifdef SH7604_RESP_TIMEOUT_EN
                        if (!ack_q && (tcnt_q == 16'(TIMEOUT - 1))) begin
                            mem_d.req = 1'b0;
                            to_err_d  = 1'b1;
                            if (cs_lost_q || CS_N) begin
                                state_d = IDLE;
                                ack_d   = 1'b0;
                            end else begin
                                state_d = DONE;
                                if (dir_q) begin
                                    do_d  = TIMEOUT_DATA;
                                    doe_d = 1'b1;
                                end
                            end
                        end else begin
                            tcnt_d = tcnt_q + 16'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    if (CS_N) begin
                        state_d = IDLE;
                        doe_d   = 1'b0;
                        ack_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            mem_q     <= '0;
            dir_q     <= 1'b0;
            wcnt_q    <= 4'd0;
            ack_q     <= 1'b0;
            ackdata_q <= 32'd0;
            cs_lost_q <= 1'b0;
            do_q      <= 32'd0;
            doe_q     <= 1'b0;
            wait_n_q  <= 1'b1;
`ifdef SH7604_RESP_TIMEOUT_EN
            tcnt_q    <= 16'd0;
            to_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            dir_q     <= dir_d;
            wcnt_q    <= wcnt_d;
            ack_q     <= ack_d;
            ackdata_q <= ackdata_d;
            cs_lost_q <= cs_lost_d;
            do_q      <= do_d;
            doe_q     <= doe_d;
            wait_n_q  <= wait_n_d;
`ifdef SH7604_RESP_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            to_err_q  <= to_err_d;
`endif
        end
    end

    assign DO      = do_q;
    assign DOE     = doe_q;
    assign WAIT_N  = wait_n_q;
    assign MEM_A   = mem_q.a;
    assign MEM_DO  = mem_q.d;
    assign MEM_BE  = mem_q.be;
    assign MEM_WE  = mem_q.we;
    assign MEM_REQ = mem_q.req;
`ifdef SH7604_RESP_TIMEOUT_EN
    assign TO_ERR  = to_err_q;
`else
    assign TO_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_sh7604_ext_responder.sv
// Directed bench for sh7604_ext_responder: two instances (MIN_WAIT 1 and 4)
// share the CPU bus and a simple auto-acking backend.
module tb_sh7604_ext_responder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE_R = 1'b0;
    logic        CE_F = 1'b0;
    logic [26:0] A = '0;
    logic [31:0] DI = '0;
    logic        CS_N = 1'b1;
    logic        BS_N = 1'b1;
    logic        RD_WR_N = 1'b1;
    logic        RD_N = 1'b1;
    logic [3:0]  WE_N = 4'hF;
    logic [31:0] MEM_DI = '0;
    logic        MEM_ACK = 1'b0;

    logic [31:0] do1, do4, memdo1, memdo4;
    logic        doe1, doe4, wait1, wait4, memwe1, memwe4, memreq1, memreq4, toerr1, toerr4;
    logic [26:0] mema1, mema4;
    logic [3:0]  membe1, membe4;

    int errors = 0;
    int checks = 0;
    int ack_en = 0;
    int ack_delay = 1;
    int req_rises = 0;
    int to_err_cnt = 0;
    logic req_prev = 1'b0;
    int phase = 0;

    sh7604_ext_responder #(.MIN_WAIT(1), .TIMEOUT(8)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .DI(DI),
        .DO(do1), .DOE(doe1), .CS_N(CS_N), .BS_N(BS_N), .RD_WR_N(RD_WR_N),
        .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(wait1), .MEM_A(mema1), .MEM_DO(memdo1),
        .MEM_BE(membe1), .MEM_WE(memwe1), .MEM_REQ(memreq1), .MEM_DI(MEM_DI),
        .MEM_ACK(MEM_ACK), .TO_ERR(toerr1)
    );

    sh7604_ext_responder #(.MIN_WAIT(4), .TIMEOUT(8)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .DI(DI),
        .DO(do4), .DOE(doe4), .CS_N(CS_N), .BS_N(BS_N), .RD_WR_N(RD_WR_N),
        .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(wait4), .MEM_A(mema4), .MEM_DO(memdo4),
        .MEM_BE(membe4), .MEM_WE(memwe4), .MEM_REQ(memreq4), .MEM_DI(MEM_DI),
        .MEM_ACK(MEM_ACK), .TO_ERR(toerr4)
    );

    always #5 CLK = ~CLK;

    // Bus clock is CLK/4: rising phase enable, then falling phase two CLKs later.
    always @(negedge CLK) begin
        phase = (phase + 1) % 4;
        CE_R  = (phase == 0);
        CE_F  = (phase == 2);
    end

    always @(posedge CLK) begin
        req_prev <= memreq1;
        if (memreq1 && !req_prev) req_rises <= req_rises + 1;
        if (toerr1) to_err_cnt <= to_err_cnt + 1;
    end

    // Backend: acks ack_delay CLKs after seeing MEM_REQ high.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (ack_en != 0 && memreq1) begin
                repeat (ack_delay - 1) @(posedge CLK);
                #2;
                MEM_ACK = 1'b1;
                @(posedge CLK);
                #2;
                MEM_ACK = 1'b0;
            end
        end
    end

    task automatic wait_cer();
        do @(posedge CLK); while (!CE_R);
        #1;
    endtask

    task automatic start_cycle(input logic rd, input logic [26:0] addr);
        A = addr; RD_WR_N = rd; RD_N = !rd; CS_N = 1'b0; BS_N = 1'b0;
        wait_cer();
        BS_N = 1'b1;
    endtask

    task automatic end_cycle(input int idle);
        CS_N = 1'b1; RD_N = 1'b1; WE_N = 4'hF; RD_WR_N = 1'b1;
        repeat (idle) wait_cer();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks += 6;
        if (do1 !== 32'd0 || doe1 !== 1'b0) begin errors++; $display("FAIL reset_do: DO=%h DOE=%b want 0/0", do1, doe1); end
        if (wait1 !== 1'b1 || wait4 !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b/%b want 1/1", wait1, wait4); end
        if (mema1 !== 27'd0 || memdo1 !== 32'd0) begin errors++; $display("FAIL reset_mem_ad: A=%h D=%h want 0", mema1, memdo1); end
        if (membe1 !== 4'd0 || memwe1 !== 1'b0) begin errors++; $display("FAIL reset_be_we: BE=%h WE=%b want 0", membe1, memwe1); end
        if (memreq1 !== 1'b0 || memreq4 !== 1'b0) begin errors++; $display("FAIL reset_req: got %b/%b want 0", memreq1, memreq4); end
        if (toerr1 !== 1'b0) begin errors++; $display("FAIL reset_toerr: got %b want 0", toerr1); end
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) wait_cer();
        $display("reset: outputs checked, reset released");
    endtask

    task automatic test_read();
        int n;
        logic seen4;
        ack_en = 1; ack_delay = 3; MEM_DI = 32'h1234_5678;
        start_cycle(1'b1, 27'h000_0100);
        checks += 2;
        if (mema1 !== 27'h000_0100 || membe1 !== 4'hF) begin errors++; $display("FAIL read_latch: A=%h BE=%h want 0000100/F", mema1, membe1); end
        if (memwe1 !== 1'b0 || memreq1 !== 1'b1) begin errors++; $display("FAIL read_req: WE=%b REQ=%b want 0/1", memwe1, memreq1); end
        wait_cer();
        checks++;
        if (wait1 !== 1'b0) begin errors++; $display("FAIL read_wait_low: WAIT_N=%b want 0", wait1); end
        n = 0;
        while (!doe1 && n < 20) begin wait_cer(); n++; end
        checks += 3;
        if (doe1 !== 1'b1) begin errors++; $display("FAIL read_doe: DOE=%b want 1 after %0d CE_R", doe1, n); end
        if (do1 !== 32'h1234_5678) begin errors++; $display("FAIL read_data: DO=%h want 12345678", do1); end
        if (wait1 !== 1'b1) begin errors++; $display("FAIL read_wait_high: WAIT_N=%b want 1", wait1); end
        CS_N = 1'b1; RD_N = 1'b1;
        wait_cer();
        checks++;
        if (doe1 !== 1'b0) begin errors++; $display("FAIL read_doe_off: DOE=%b want 0", doe1); end
        seen4 = 1'b0;
        repeat (8) begin wait_cer(); seen4 |= doe4; end
        checks++;
        if (seen4 !== 1'b0) begin errors++; $display("FAIL read_cs_lost_doe: DOE(MW4)=%b want 0", seen4); end
        $display("read A=0000100 DO=%h", do1);
    endtask

    task automatic test_byte_write();
        int rises0, n;
        logic seen_doe;
        ack_en = 1; ack_delay = 2;
        rises0 = req_rises;
        start_cycle(1'b0, 27'h000_0200);
        DI = 32'h00AB_0000; WE_N = 4'b1011;
        checks++;
        if (memreq1 !== 1'b0) begin errors++; $display("FAIL write_no_early_req: REQ=%b want 0", memreq1); end
        wait_cer();
        checks += 2;
        if (membe1 !== 4'b0100 || memdo1 !== 32'h00AB_0000) begin errors++; $display("FAIL write_latch: BE=%b D=%h want 0100/00ab0000", membe1, memdo1); end
        if (memwe1 !== 1'b1 || memreq1 !== 1'b1) begin errors++; $display("FAIL write_req: WE=%b REQ=%b want 1/1", memwe1, memreq1); end
        seen_doe = 1'b0; n = 0;
        while (!wait1 && n < 20) begin wait_cer(); seen_doe |= doe1; n++; end
        checks++;
        if (wait1 !== 1'b1) begin errors++; $display("FAIL write_wait_release: WAIT_N=%b want 1", wait1); end
        end_cycle(0);
        repeat (8) begin wait_cer(); seen_doe |= doe1 | doe4; end
        checks += 3;
        if (req_rises - rises0 != 1) begin errors++; $display("FAIL write_single_req: %0d requests want 1", req_rises - rises0); end
        if (seen_doe !== 1'b0) begin errors++; $display("FAIL write_doe: DOE seen %b want 0", seen_doe); end
        if (memreq1 !== 1'b0) begin errors++; $display("FAIL write_req_drop: REQ=%b want 0", memreq1); end
        $display("write A=0000200 BE=%b D=%h", membe1, memdo1);
    endtask

    task automatic test_min_wait();
        int lows1, lows4;
        ack_en = 1; ack_delay = 1; MEM_DI = 32'h5A5A_0F0F;
        start_cycle(1'b1, 27'h7FF_FFFC);
        lows1 = 0; lows4 = 0;
        repeat (10) begin
            wait_cer();
            if (!wait1) lows1++;
            if (!wait4) lows4++;
        end
        checks += 4;
        if (lows4 != 4) begin errors++; $display("FAIL min_wait4: WAIT_N low %0d CE_R want 4", lows4); end
        if (lows1 != 1) begin errors++; $display("FAIL min_wait1: WAIT_N low %0d CE_R want 1", lows1); end
        if (do4 !== 32'h5A5A_0F0F || doe4 !== 1'b1) begin errors++; $display("FAIL min_wait_data: DO=%h DOE=%b want 5a5a0f0f/1", do4, doe4); end
        if (mema4 !== 27'h7FF_FFFC) begin errors++; $display("FAIL min_wait_addr: A=%h want 7fffffc", mema4); end
        end_cycle(3);
        checks++;
        if (doe4 !== 1'b0) begin errors++; $display("FAIL min_wait_doe_off: DOE=%b want 0", doe4); end
        $display("read A=7fffffc waits mw1=%0d mw4=%0d", lows1, lows4);
    endtask

    task automatic test_wdata_abort();
        int rises0;
        rises0 = req_rises;
        start_cycle(1'b0, 27'h000_0300);
        wait_cer();
        checks++;
        if (wait1 !== 1'b0) begin errors++; $display("FAIL abort_wait_low: WAIT_N=%b want 0", wait1); end
        CS_N = 1'b1;
        wait_cer();
        wait_cer();
        WE_N = 4'b0000;
        wait_cer();
        checks += 3;
        if (wait1 !== 1'b1 || wait4 !== 1'b1) begin errors++; $display("FAIL abort_wait_high: WAIT_N=%b/%b want 1", wait1, wait4); end
        if (memreq1 !== 1'b0 || req_rises != rises0) begin errors++; $display("FAIL abort_no_req: REQ=%b rises=%0d want 0/0", memreq1, req_rises - rises0); end
        if (doe1 !== 1'b0) begin errors++; $display("FAIL abort_doe: DOE=%b want 0", doe1); end
        end_cycle(2);
        $display("write abort A=0000300 no request");
    endtask

    task automatic test_no_ack();
        int n, to0;
        ack_en = 0;
        to0 = to_err_cnt;
        start_cycle(1'b1, 27'h000_0400);
        n = 0;
`ifdef SH7604_RESP_TIMEOUT_EN
        while (!doe1 && n < 20) begin wait_cer(); n++; end
        checks += 3;
        if (n != 8 || toerr1 !== 1'b1) begin errors++; $display("FAIL timeout_when: %0d CE_R TO_ERR=%b want 8/1", n, toerr1); end
        if (do1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_data: DO=%h want ffffffff", do1); end
        if (memreq1 !== 1'b0) begin errors++; $display("FAIL timeout_req: REQ=%b want 0", memreq1); end
        wait_cer();
        checks += 2;
        if (wait1 !== 1'b1) begin errors++; $display("FAIL timeout_wait: WAIT_N=%b want 1", wait1); end
        if (to_err_cnt - to0 != 1) begin errors++; $display("FAIL timeout_pulse: %0d pulses want 1", to_err_cnt - to0); end
        MEM_DI = 32'h1111_1111;
        @(posedge CLK); #2 MEM_ACK = 1'b1;
        @(posedge CLK); #2 MEM_ACK = 1'b0;
        wait_cer();
        checks++;
        if (do1 !== 32'hFFFF_FFFF || to_err_cnt - to0 != 1) begin errors++; $display("FAIL timeout_stray_ack: DO=%h pulses=%0d want ffffffff/1", do1, to_err_cnt - to0); end
`else
        repeat (20) wait_cer();
        checks += 2;
        if (wait1 !== 1'b0 || doe1 !== 1'b0) begin errors++; $display("FAIL noack_hold: WAIT_N=%b DOE=%b want 0/0", wait1, doe1); end
        if (to_err_cnt != to0 || memreq1 !== 1'b1) begin errors++; $display("FAIL noack_req: REQ=%b pulses=%0d want 1/0", memreq1, to_err_cnt - to0); end
        MEM_DI = 32'h0BAD_F00D; ack_delay = 1; ack_en = 1;
        while (!doe1 && n < 20) begin wait_cer(); n++; end
        checks++;
        if (do1 !== 32'h0BAD_F00D || doe1 !== 1'b1) begin errors++; $display("FAIL noack_late: DO=%h DOE=%b want 0badf00d/1", do1, doe1); end
`endif
        end_cycle(8);
        ack_en = 1;
        $display("read A=0000400 no-ack DO=%h", do1);
    endtask

    task automatic test_reset_midcycle();
        int n;
        ack_en = 0;
        start_cycle(1'b1, 27'h000_0500);
        repeat (2) wait_cer();
        checks++;
        if (memreq1 !== 1'b1 || wait1 !== 1'b0) begin errors++; $display("FAIL rst_pre: REQ=%b WAIT_N=%b want 1/0", memreq1, wait1); end
        #3 RST_N = 1'b0;
        #1;
        checks += 2;
        if (memreq1 !== 1'b0 || wait1 !== 1'b1) begin errors++; $display("FAIL rst_async: REQ=%b WAIT_N=%b want 0/1", memreq1, wait1); end
        if (mema1 !== 27'd0 || doe1 !== 1'b0) begin errors++; $display("FAIL rst_async_state: A=%h DOE=%b want 0/0", mema1, doe1); end
        end_cycle(0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) wait_cer();
        ack_en = 1; ack_delay = 2; MEM_DI = 32'hCAFE_F00D;
        start_cycle(1'b1, 27'h000_0040);
        n = 0;
        while (!doe1 && n < 20) begin wait_cer(); n++; end
        checks++;
        if (do1 !== 32'hCAFE_F00D || mema1 !== 27'h000_0040) begin errors++; $display("FAIL rst_next_read: DO=%h A=%h want cafef00d/0000040", do1, mema1); end
        end_cycle(8);
        $display("read after reset A=0000040 DO=%h", do1);
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_min_wait();
        test_wdata_abort();
        test_no_ack();
        test_reset_midcycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
